// File: rtl/col_compress_pipe_if.sv
// Column-compressor bus: the squarer drives the word set and neighbour word and reads back the three sums.
// There is no backpressure: in_valid qualifies Adder_A, Adder_B belongs to the cycle after in_valid, and out_valid qualifies S/S2x/S3x.
interface col_compress_pipe_if #(
   parameter int N_IN  = 66,
   parameter int W     = 25,
   parameter int OUT_W = 26
) ();
   logic                     in_valid;
   logic [N_IN-1:0][W-1:0]   Adder_A;
   logic [W-1:0]             Adder_B;
   logic                     out_valid;
   logic [OUT_W-1:0]         S;
   logic [OUT_W-1:0]         S2x;
   logic [OUT_W-1:0]         S3x;

   modport master (
      output in_valid, Adder_A, Adder_B,
      input  out_valid, S, S2x, S3x
   );

   modport slave (
      input  in_valid, Adder_A, Adder_B,
      output out_valid, S, S2x, S3x
   );
endinterface

// File: rtl/col_compress_pipe.sv
// Pipelined column compressor: CSA tree to a registered carry-save pair, then merge with the neighbour word.
// Define COL_CMP_OUTREG_EN to register S/S2x/S3x/out_valid (latency 2); otherwise the outputs are combinational (latency 1).
module col_compress_pipe #(
   parameter int N_IN  = 66,
   parameter int W     = 25,
   parameter int OUT_W = 26
) (
   input  logic clk_sq,
   input  logic reset_sq,
   col_compress_pipe_if.slave bus
);
   localparam int TW = W + $clog2(N_IN) + 2;
   localparam int MW = TW + 2;

   function automatic int next_cnt(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int cnt_at(input int lvl);
      int n;
      n = N_IN;
      for (int i = 0; i < lvl; i++) begin
         if (n > 2) n = next_cnt(n);
      end
      return n;
   endfunction

   function automatic int num_levels();
      int n;
      int l;
      n = N_IN;
      l = 0;
      while (n > 2) begin
         n = next_cnt(n);
         l++;
      end
      return l;
   endfunction

   localparam int NL = num_levels();

   // Each level owns its own word arrays so no comb loop appears through a shared array.
   for (genvar l = 0; l < NL; l++) begin : g_lvl
      localparam int NC = cnt_at(l);
      localparam int NG = NC / 3;
      localparam int NR = NC % 3;
      localparam int NN = 2 * NG + NR;

      logic [TW-1:0] w_in  [NC];
      logic [TW-1:0] w_out [NN];

      if (l == 0) begin : g_first
         for (genvar i = 0; i < N_IN; i++) begin : g_ext
            assign w_in[i] = TW'(bus.Adder_A[i]);
         end
      end else begin : g_next
         assign w_in = g_lvl[l-1].w_out;
      end

      for (genvar g = 0; g < NG; g++) begin : g_csa
         assign w_out[2*g]   = w_in[3*g] ^ w_in[3*g+1] ^ w_in[3*g+2];
         assign w_out[2*g+1] = ((w_in[3*g] & w_in[3*g+1]) |
                                (w_in[3*g] & w_in[3*g+2]) |
                                (w_in[3*g+1] & w_in[3*g+2])) << 1;
      end

      for (genvar r = 0; r < NR; r++) begin : g_pass
         assign w_out[2*NG+r] = w_in[3*NG+r];
      end
   end

   logic [TW-1:0] tree_s;
   logic [TW-1:0] tree_c;
   assign tree_s = g_lvl[NL-1].w_out[0];
   assign tree_c = g_lvl[NL-1].w_out[1];

   logic [TW-1:0] c1;
   logic [TW-1:0] s1;
   logic          v1;

   always_ff @(posedge clk_sq) begin
      if (reset_sq) begin
         c1 <= '0;
         s1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            c1 <= tree_c;
            s1 <= tree_s;
         end
      end
   end

   // Two 3:2 levels form the 4:2 reduction; dropped carries lie above MW, so the result is exact mod 2^MW.
   function automatic logic [MW-1:0] add4(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                          input logic [MW-1:0] c, input logic [MW-1:0] d);
      logic [MW-1:0] sa;
      logic [MW-1:0] ca;
      logic [MW-1:0] sb;
      logic [MW-1:0] cb;
      sa = a ^ b ^ c;
      ca = ((a & b) | (a & c) | (b & c)) << 1;
      sb = sa ^ ca ^ d;
      cb = ((sa & ca) | (sa & d) | (ca & d)) << 1;
      return sb + cb;
   endfunction

   logic [MW-1:0] c1_w;
   logic [MW-1:0] s1_w;
   logic [MW-1:0] b_w;
   assign c1_w = MW'(c1);
   assign s1_w = MW'(s1);
   assign b_w  = MW'(bus.Adder_B);

   logic [OUT_W-1:0] res_s;
   logic [OUT_W-1:0] res_s2x;
   logic [OUT_W-1:0] res_s3x;
   assign res_s   = OUT_W'(add4(c1_w, s1_w, b_w, '0));
   assign res_s2x = OUT_W'(add4(c1_w << 1, s1_w << 1, b_w, '0));
   assign res_s3x = OUT_W'(add4(c1_w, s1_w, b_w, b_w));

`ifdef COL_CMP_OUTREG_EN
   always_ff @(posedge clk_sq) begin
      if (reset_sq) begin
         bus.out_valid <= 1'b0;
         bus.S         <= '0;
         bus.S2x       <= '0;
         bus.S3x       <= '0;
      end else begin
         bus.out_valid <= v1;
         if (v1) begin
            bus.S   <= res_s;
            bus.S2x <= res_s2x;
            bus.S3x <= res_s3x;
         end
      end
   end
`else
   // A reset landing in the merge cycle discards that transaction, so it never shows valid.
   assign bus.out_valid = v1 & ~reset_sq;
   assign bus.S         = res_s;
   assign bus.S2x       = res_s2x;
   assign bus.S3x       = res_s3x;
`endif
endmodule

// File: tb/tb_col_compress_pipe.sv
// Bench for col_compress_pipe: a default-size instance (66x25) and a degenerate one (3x8, narrow output)
// driven from one random stream and checked each cycle against a history-based arithmetic model.
module tb_col_compress_pipe;
   localparam int MAXC = 512;
`ifdef COL_CMP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk_sq = 1'b0;
   logic reset_sq;
   always #5 clk_sq = ~clk_sq;

   col_compress_pipe_if #(.N_IN(66), .W(25), .OUT_W(26)) bus0 ();
   col_compress_pipe_if #(.N_IN(3),  .W(8),  .OUT_W(9))  bus1 ();

   col_compress_pipe #(.N_IN(66), .W(25), .OUT_W(26)) u_dut0 (
      .clk_sq   (clk_sq),
      .reset_sq (reset_sq),
      .bus      (bus0)
   );

   col_compress_pipe #(.N_IN(3), .W(8), .OUT_W(9)) u_dut1 (
      .clk_sq   (clk_sq),
      .reset_sq (reset_sq),
      .bus      (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit running  = 1'b0;

   // stimulus history per cycle: in_valid, reset, sum(Adder_A), Adder_B
   bit              h_iv  [MAXC];
   bit              h_rst [MAXC];
   longint unsigned h_sum [2][MAXC];
   longint unsigned h_b   [2][MAXC];

   int              ow [2] = '{26, 9};
   longint unsigned m_reg [2];
   longint unsigned m_hs  [2];
   longint unsigned m_h2  [2];
   longint unsigned m_h3  [2];

   function automatic void model(input longint unsigned sum, input longint unsigned b, input int w_out,
                                 output longint unsigned r1, output longint unsigned r2,
                                 output longint unsigned r3);
      longint unsigned m;
      m  = (64'd1 << w_out) - 64'd1;
      r1 = (sum + b) & m;
      r2 = (2 * sum + b) & m;
      r3 = (sum + 2 * b) & m;
   endfunction

   task automatic chk(input int k, input string nm, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL u%0d %s cyc=%0d: got %0d, expected %0d", k, nm, cyc, act, exp);
      end
   endtask

   task automatic check_inst(input int k, input int c, input bit ov, input longint unsigned s,
                             input longint unsigned s2, input longint unsigned s3);
      bit ev;
      longint unsigned e1, e2, e3;
      // a set survives when neither its own cycle nor the following (Adder_B) cycle is in reset
      ev = (c >= LAT) && h_iv[c-LAT] && !h_rst[c-LAT] && !h_rst[c-LAT+1];
      chk(k, "out_valid", 64'(ov), 64'(ev));
`ifdef COL_CMP_OUTREG_EN
      if (h_rst[c-1]) begin
         m_hs[k] = 0;
         m_h2[k] = 0;
         m_h3[k] = 0;
      end
      if (ev) model(h_sum[k][c-2], h_b[k][c-1], ow[k], m_hs[k], m_h2[k], m_h3[k]);
      e1 = m_hs[k];
      e2 = m_h2[k];
      e3 = m_h3[k];
`else
      if (h_rst[c-1]) m_reg[k] = 0;
      else if (h_iv[c-1]) m_reg[k] = h_sum[k][c-1];
      model(m_reg[k], h_b[k][c], ow[k], e1, e2, e3);
`endif
      chk(k, "S", s, e1);
      chk(k, "S2x", s2, e2);
      chk(k, "S3x", s3, e3);
   endtask

   always @(negedge clk_sq) begin
      if (running) begin
         check_inst(0, cyc, bus0.out_valid, 64'(bus0.S), 64'(bus0.S2x), 64'(bus0.S3x));
         check_inst(1, cyc, bus1.out_valid, 64'(bus1.S), 64'(bus1.S2x), 64'(bus1.S3x));
      end
   end

   // apat/bpat: 0 random, 1 Adder_A=1 / Adder_B=5, 2 all ones
   task automatic drive(input bit iv, input bit rst, input int apat, input int bpat);
      logic [24:0] a;
      logic [24:0] b;
      longint unsigned s0;
      longint unsigned s1;
      s0 = 0;
      s1 = 0;
      for (int i = 0; i < 66; i++) begin
         case (apat)
            1:       a = 25'd1;
            2:       a = 25'h1FFFFFF;
            default: a = 25'($urandom_range(0, 32'h1FFFFFF));
         endcase
         bus0.Adder_A[i] = a;
         s0 += 64'(a);
         if (i < 3) begin
            bus1.Adder_A[i] = a[7:0];
            s1 += 64'(a[7:0]);
         end
      end
      case (bpat)
         1:       b = 25'd5;
         2:       b = 25'h1FFFFFF;
         default: b = 25'($urandom_range(0, 32'h1FFFFFF));
      endcase
      bus0.Adder_B  = b;
      bus1.Adder_B  = b[7:0];
      bus0.in_valid = iv;
      bus1.in_valid = iv;
      reset_sq      = rst;
      h_iv[cyc]     = iv;
      h_rst[cyc]    = rst;
      h_sum[0][cyc] = s0;
      h_sum[1][cyc] = s1;
      h_b[0][cyc]   = 64'(b);
      h_b[1][cyc]   = 64'(b[7:0]);
      @(posedge clk_sq);
      #1;
      cyc++;
   endtask

   initial begin
      longint unsigned p1, p2, p3;
      longint unsigned mx;
      running = 1'b1;

      // reset held two cycles while in_valid carries random data
      repeat (2) drive(1'b1, 1'b1, 0, 0);

      // all-ones-word set (Adder_A=1), Adder_B=5 one cycle later
      drive(1'b1, 1'b0, 1, 0);
      drive(1'b0, 1'b0, 0, 1);
      repeat (2) drive(1'b0, 1'b0, 0, 0);

      // maximum values
      drive(1'b1, 1'b0, 2, 0);
      drive(1'b0, 1'b0, 0, 2);
      repeat (2) drive(1'b0, 1'b0, 0, 0);

      // back-to-back random sets
      repeat (100) drive(1'b1, 1'b0, 0, 0);
      repeat (2) drive(1'b0, 1'b0, 0, 0);

      // hold after a single set
      drive(1'b1, 1'b0, 0, 0);
      repeat (5) drive(1'b0, 1'b0, 0, 0);

      // mid-flight reset, then a clean set
      drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 0, 0);
      drive(1'b1, 1'b0, 0, 0);
      repeat (3) drive(1'b0, 1'b0, 0, 0);

      // random mix with sporadic resets
      repeat (150) drive(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), 0, 0);
      repeat (3) drive(1'b0, 1'b0, 0, 0);
      running = 1'b0;

      // literal pins for the model itself
      mx = 64'd33554431;
      model(64'd66, 64'd5, 26, p1, p2, p3);
      chk(0, "pin_ones_S", p1, 64'd71);
      chk(0, "pin_ones_S2x", p2, 64'd137);
      chk(0, "pin_ones_S3x", p3, 64'd76);
      model(66 * mx, mx, 26, p1, p2, p3);
      chk(0, "pin_max_S", p1, 64'd33554365);
      chk(0, "pin_max_S2x", p2, 64'd33554299);
      chk(0, "pin_max_S3x", p3, 64'd67108796);
      model(64'd3, 64'd5, 9, p1, p2, p3);
      chk(1, "pin_ones_S", p1, 64'd8);
      chk(1, "pin_ones_S2x", p2, 64'd11);
      chk(1, "pin_ones_S3x", p3, 64'd13);
      model(64'd765, 64'd255, 9, p1, p2, p3);
      chk(1, "pin_max_S", p1, 64'd508);
      chk(1, "pin_max_S2x", p2, 64'd249);
      chk(1, "pin_max_S3x", p3, 64'd251);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
